// File: rtl/slot_sched.sv
// Purpose : per-slot sequencer; latches one parameter set, launches matrix
//           generation, gates exactly MAT_RANK samples to the multiplier,
//           then waits for the multiplier before taking the next set.
// Latency : sample path is combinational (zero latency) while streaming;
//           control outputs are registered. Minimum slot period MAT_RANK+4.
// Backpressure: src_rdy follows mm_rdy only while streaming, else 0;
//           param_rdy only in IDLE, gen_rdy only in GEN.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   abort              synchronous return to IDLE, highest priority
//   param_in/_vld/_rdy parameter bundle {x1,x2,x3,z1,z2}, handshake in IDLE
//   param_q            parameters held stable for the whole slot
//   gen_start          one-cycle pulse on entry to GEN
//   gen_vld/gen_rdy    sparse-matrix-ready handshake, GEN only
//   src_vld/src_rdy    upstream sample handshake
//   mm_vld/mm_rdy      multiplier sample handshake, mm_last on final sample
//   sample_idx         index of the sample currently presented
//   mm_done            multiplier finished the slot (observed in DRAIN only)
//   slot_done          one-cycle pulse at slot end
//   slot_cnt           completed-slot count, wraps
//   busy               state != IDLE
//   err                sticky GEN timeout flag, cleared only by reset

module slot_sched #(
   parameter int  SUBCAR_NUM   = 16,
   parameter int  OFDM_SYM_NUM = 16,
   parameter int  PARAM_W      = 160,
   parameter int  CNT_W        = 16,
   parameter int  GEN_TIMEOUT  = 1024,
   localparam int MAT_RANK     = SUBCAR_NUM * OFDM_SYM_NUM,
   localparam int IDX_W        = (MAT_RANK > 1) ? $clog2(MAT_RANK) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               abort,
   input  logic [PARAM_W-1:0] param_in,
   input  logic               param_vld,
   output logic               param_rdy,
   output logic [PARAM_W-1:0] param_q,
   output logic               gen_start,
   input  logic               gen_vld,
   output logic               gen_rdy,
   input  logic               src_vld,
   output logic               src_rdy,
   output logic               mm_vld,
   input  logic               mm_rdy,
   output logic               mm_last,
   output logic [IDX_W-1:0]   sample_idx,
   input  logic               mm_done,
   output logic               slot_done,
   output logic [CNT_W-1:0]   slot_cnt,
   output logic               busy,
   output logic               err
);

   // Timeout counter must hold GEN_TIMEOUT-1; +1 keeps width >= 1 for tiny values.
   localparam int                TO_W     = $clog2(GEN_TIMEOUT + 1);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(GEN_TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(MAT_RANK - 1);

   // DONE exists so slot_done is seen while still busy; param_rdy then
   // rises the cycle after the pulse.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GEN    = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t             state_q;
   logic [TO_W-1:0]    to_cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic               gen_start_q;
   logic               slot_done_q;
   logic [CNT_W-1:0]   slot_cnt_q;
   logic               err_q;

   logic               in_stream;
   logic               mm_hs;
   logic               idx_last;

   // ---------------------------------------------------------------
   // State-derived handshakes and the zero-latency sample pass-through
   // ---------------------------------------------------------------
   assign in_stream = (state_q == S_STREAM);
   assign idx_last  = (idx_q == IDX_LAST);

   assign param_rdy = (state_q == S_IDLE);
   assign gen_rdy   = (state_q == S_GEN);
   assign busy      = (state_q != S_IDLE);

   assign mm_vld    = in_stream & src_vld;
   assign src_rdy   = in_stream & mm_rdy;
   assign mm_last   = in_stream & idx_last;
   assign mm_hs     = in_stream & src_vld & mm_rdy;

   assign gen_start  = gen_start_q;
   assign sample_idx = idx_q;
   assign slot_done  = slot_done_q;
   assign slot_cnt   = slot_cnt_q;
   assign err        = err_q;

   // ---------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         param_q     <= '0;
         to_cnt_q    <= '0;
         idx_q       <= '0;
         gen_start_q <= 1'b0;
         slot_done_q <= 1'b0;
         slot_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         // Pulses default low every cycle.
         gen_start_q <= 1'b0;
         slot_done_q <= 1'b0;

         if (abort) begin
            // Abort discards whatever handshake coincides with it; param_q,
            // slot_cnt and err are deliberately left alone.
            state_q  <= S_IDLE;
            idx_q    <= '0;
            to_cnt_q <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (param_vld) begin
                     param_q     <= param_in;
                     gen_start_q <= 1'b1;
                     to_cnt_q    <= '0;
                     state_q     <= S_GEN;
                  end
               end

               S_GEN: begin
                  // A handshake on the final allowed cycle beats the timeout.
                  if (gen_vld) begin
                     idx_q    <= '0;
                     to_cnt_q <= '0;
                     state_q  <= S_STREAM;
                  end else if (to_cnt_q == TO_LAST) begin
                     err_q    <= 1'b1;
                     to_cnt_q <= '0;
                     state_q  <= S_IDLE;
                  end else begin
                     to_cnt_q <= to_cnt_q + 1'b1;
                  end
               end

               S_STREAM: begin
                  if (mm_hs) begin
                     if (idx_last) begin
                        idx_q   <= '0;
                        state_q <= S_DRAIN;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end
               end

               S_DRAIN: begin
                  if (mm_done) begin
                     slot_done_q <= 1'b1;
                     slot_cnt_q  <= slot_cnt_q + 1'b1;
                     state_q     <= S_DONE;
                  end
               end

               S_DONE: begin
                  state_q <= S_IDLE;
               end

               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_slot_sched.sv
// Purpose : self-checking bench for slot_sched (MAT_RANK=256, CNT_W=2, GEN_TIMEOUT=8).
// Latency : expects zero-latency sample pass-through and MAT_RANK+4 slot period.
// Backpressure: drives mm_rdy toggling and random src_vld in one slot.

module tb_slot_sched;

   localparam int PW = 160;
   localparam int CW = 2;
   localparam int MR = 256;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          abort = 1'b0;
   logic [PW-1:0] param_in = '0;
   logic          param_vld = 1'b0;
   logic          gen_vld = 1'b0;
   logic          src_vld = 1'b0;
   logic          mm_rdy = 1'b0;
   logic          mm_done = 1'b0;

   logic          param_rdy;
   logic [PW-1:0] param_q;
   logic          gen_start;
   logic          gen_rdy;
   logic          src_rdy;
   logic          mm_vld;
   logic          mm_last;
   logic [IW-1:0] sample_idx;
   logic          slot_done;
   logic [CW-1:0] slot_cnt;
   logic          busy;
   logic          err;

   always #5 clk = ~clk;

   slot_sched #(
      .SUBCAR_NUM  (16),
      .OFDM_SYM_NUM(16),
      .PARAM_W     (PW),
      .CNT_W       (CW),
      .GEN_TIMEOUT (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .abort     (abort),
      .param_in  (param_in),
      .param_vld (param_vld),
      .param_rdy (param_rdy),
      .param_q   (param_q),
      .gen_start (gen_start),
      .gen_vld   (gen_vld),
      .gen_rdy   (gen_rdy),
      .src_vld   (src_vld),
      .src_rdy   (src_rdy),
      .mm_vld    (mm_vld),
      .mm_rdy    (mm_rdy),
      .mm_last   (mm_last),
      .sample_idx(sample_idx),
      .mm_done   (mm_done),
      .slot_done (slot_done),
      .slot_cnt  (slot_cnt),
      .busy      (busy),
      .err       (err)
   );

   int            n_chk = 0;
   int            n_fail = 0;
   logic [PW-1:0] exp_param = '0;
   logic [CW-1:0] exp_cnt = '0;
   logic [IW:0]   exp_q[$];      // {mm_last, sample_idx} per expected handshake
   logic [CW-1:0] cnt_q[$];      // slot_cnt expected at each slot_done
   int            done_seen = 0;
   int            gen_pulses = 0;
   int            cyc_n = 0;
   int            gs_times[$];
   logic          prev_done = 1'b0;

   task automatic check_val(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: mid-cycle sampling sees exactly what commits at the next edge.
   always @(negedge clk) begin
      cyc_n++;
      if (rst_n) begin
         if (mm_vld && mm_rdy) begin
            if (exp_q.size() == 0) check_val("mm_extra_hs", 1, 0);
            else check_val("mm_idx_last", {mm_last, sample_idx}, exp_q.pop_front());
         end
         if (slot_done) begin
            done_seen++;
            check_val("rdy_low_at_done", param_rdy, 0);
            if (cnt_q.size() == 0) check_val("slot_done_extra", 1, 0);
            else check_val("slot_cnt", slot_cnt, cnt_q.pop_front());
         end
         if (prev_done) check_val("rdy_after_done", param_rdy, 1);
         if (busy) check_val("param_hold", param_q, exp_param);
         if (gen_start) begin
            gen_pulses++;
            gs_times.push_back(cyc_n);
         end
         check_val("src_rdy_gated", src_rdy & ~mm_rdy, 0);
         prev_done = slot_done;
      end else begin
         prev_done = 1'b0;
      end
   end

   // cut_mode: 0 full slot, 1 abort after cut_at samples, 2 async reset after cut_at samples
   task automatic do_slot(input logic [PW-1:0] p, input int gen_delay, input bit bp,
                          input int done_delay, input int cut_mode, input int cut_at,
                          input bit gate);
      int n;
      int cyc;
      int n_exp;
      bit mr_t;
      n_exp = (cut_mode == 0) ? MR : cut_at;
      for (int i = 0; i < n_exp; i++) begin
         logic [IW:0] e;
         e = {(i == MR - 1), i[IW-1:0]};
         exp_q.push_back(e);
      end

      if (gate) begin
         src_vld = 1'b1; mm_rdy = 1'b1; mm_done = 1'b1;
         #1;
         check_val("gate_idle_mm_vld", mm_vld, 0);
         check_val("gate_idle_src_rdy", src_rdy, 0);
         tick();
         check_val("idle_ignores_done", param_rdy, 1);
         check_val("idle_not_busy", busy, 0);
         src_vld = 1'b0; mm_rdy = 1'b0; mm_done = 1'b0;
      end

      exp_param = p; param_in = p; param_vld = 1'b1;
      cyc = 0;
      while (!param_rdy && cyc < 50) begin tick(); cyc++; end
      check_val("param_rdy_wait", param_rdy, 1);
      tick();
      param_vld = 1'b0;
      param_in  = ~p;
      check_val("gen_start_pulse", gen_start, 1);
      check_val("gen_rdy", gen_rdy, 1);
      check_val("param_latch", param_q, p);

      for (int k = 0; k < gen_delay; k++) begin
         src_vld = 1'b1; mm_rdy = 1'b1; mm_done = k[0];
         #1;
         check_val("gate_gen_mm_vld", mm_vld, 0);
         check_val("gate_gen_src_rdy", src_rdy, 0);
         tick();
      end
      check_val("gen_still_waiting", gen_rdy, 1);
      src_vld = 1'b0; mm_rdy = 1'b0; mm_done = 1'b0; gen_vld = 1'b1;
      tick();
      gen_vld = 1'b0;

      n = 0; cyc = 0; mr_t = 1'b0;
      while (n < n_exp && cyc < 4000) begin
         logic sv, mr;
         sv = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         mr = bp ? mr_t : 1'b1;
         mr_t = ~mr_t;
         src_vld = sv; mm_rdy = mr;
         #1;
         check_val("pass_src_rdy", src_rdy, mr);
         check_val("pass_mm_vld", mm_vld, sv);
         if (sv && mr) n++;
         tick();
         cyc++;
      end
      check_val("stream_count", n, n_exp);
      src_vld = 1'b0; mm_rdy = 1'b0;

      if (cut_mode == 1) begin
         check_val("pre_abort_idx", sample_idx, cut_at);
         abort = 1'b1;
         tick();
         abort = 1'b0;
         check_val("abort_idle", busy, 0);
         check_val("abort_param_rdy", param_rdy, 1);
         check_val("abort_idx", sample_idx, 0);
         check_val("abort_no_done", slot_done, 0);
         check_val("abort_cnt", slot_cnt, exp_cnt);
         check_val("abort_param_q", param_q, p);
         for (int k = 0; k < 3; k++) begin
            tick();
            check_val("no_done_after_abort", slot_done, 0);
         end
      end else if (cut_mode == 2) begin
         src_vld = 1'b1; mm_rdy = 1'b1;
         rst_n = 1'b0;
         #1;
         exp_param = '0;
         exp_cnt   = '0;
         check_val("rst_busy", busy, 0);
         check_val("rst_idx", sample_idx, 0);
         check_val("rst_err", err, 0);
         check_val("rst_param_q", param_q, 0);
         check_val("rst_cnt", slot_cnt, 0);
         check_val("rst_param_rdy", param_rdy, 1);
         check_val("rst_mm_vld", mm_vld, 0);
         check_val("rst_src_rdy", src_rdy, 0);
         tick();
         rst_n = 1'b1; src_vld = 1'b0; mm_rdy = 1'b0;
         tick();
      end else begin
         for (int k = 0; k < done_delay - 1; k++) begin
            src_vld = 1'b1; mm_rdy = 1'b1;
            #1;
            check_val("gate_drain_mm_vld", mm_vld, 0);
            check_val("gate_drain_src_rdy", src_rdy, 0);
            check_val("drain_no_done", slot_done, 0);
            tick();
         end
         src_vld = 1'b0; mm_rdy = 1'b0;
         exp_cnt = exp_cnt + 1'b1;
         cnt_q.push_back(exp_cnt);
         mm_done = 1'b1;
         tick();
         mm_done = 1'b0;
         check_val("slot_done_pulse", slot_done, 1);
         check_val("slot_cnt_done", slot_cnt, exp_cnt);
         check_val("busy_at_done", busy, 1);
         tick();
         check_val("done_one_cycle", slot_done, 0);
         check_val("idle_after_done", busy, 0);
      end
      check_val("sb_empty", exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PW-1:0] p_nom;
      int cyc;
      int g0;
      int d0;
      p_nom = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h0000_00A5};

      // Reset values, with live inputs to prove gating.
      src_vld = 1'b1; mm_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_param_q", param_q, 0);
      check_val("reset_gen_start", gen_start, 0);
      check_val("reset_idx", sample_idx, 0);
      check_val("reset_slot_done", slot_done, 0);
      check_val("reset_slot_cnt", slot_cnt, 0);
      check_val("reset_err", err, 0);
      check_val("reset_param_rdy", param_rdy, 1);
      check_val("reset_busy", busy, 0);
      check_val("reset_gen_rdy", gen_rdy, 0);
      check_val("reset_mm_vld", mm_vld, 0);
      check_val("reset_src_rdy", src_rdy, 0);
      src_vld = 1'b0; mm_rdy = 1'b0;
      rst_n = 1'b1;
      tick();

      // Nominal slot with gating probes in IDLE/GEN/DRAIN.
      do_slot(p_nom, 5, 1'b0, 3, 0, 0, 1'b1);

      // Backpressure slot.
      do_slot({5{32'hC0DE_0001}}, 2, 1'b1, 2, 0, 0, 1'b0);

      // GEN timeout: eight GEN cycles without gen_vld.
      exp_param = {5{32'hDEAD_0008}};
      param_in  = exp_param;
      param_vld = 1'b1;
      cyc = 0;
      while (!param_rdy && cyc < 50) begin tick(); cyc++; end
      tick();
      param_vld = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check_val("to_gen_rdy", gen_rdy, 1);
         check_val("to_err_low", err, 0);
         tick();
      end
      check_val("to_err_set", err, 1);
      check_val("to_param_rdy", param_rdy, 1);
      check_val("to_idle", busy, 0);
      check_val("to_cnt_kept", slot_cnt, exp_cnt);
      check_val("to_param_q", param_q, {5{32'hDEAD_0008}});

      // Follow-up slot after timeout; err stays sticky.
      do_slot({5{32'h0BAD_F00D}}, 1, 1'b0, 1, 0, 0, 1'b0);
      check_val("err_sticky", err, 1);

      // Abort at sample 100, then a full slot.
      do_slot({5{32'hAB0B_0064}}, 2, 1'b0, 1, 1, 100, 1'b0);
      do_slot({5{32'h5EED_0005}}, 0, 1'b0, 2, 0, 0, 1'b0);
      check_val("cnt_wrap_single", slot_cnt, 0);

      // Async reset mid-stream.
      do_slot({5{32'h0000_7777}}, 1, 1'b0, 1, 2, 10, 1'b0);
      check_val("err_cleared", err, 0);

      // Five back-to-back slots with everything held ready.
      exp_param = {5{32'hB2B0_B2B0}};
      param_in  = exp_param;
      for (int s = 0; s < 5; s++) begin
         for (int i = 0; i < MR; i++) begin
            logic [IW:0] e;
            e = {(i == MR - 1), i[IW-1:0]};
            exp_q.push_back(e);
         end
         exp_cnt = exp_cnt + 1'b1;
         cnt_q.push_back(exp_cnt);
      end
      gs_times.delete();
      g0 = gen_pulses;
      d0 = done_seen;
      param_vld = 1'b1; gen_vld = 1'b1; src_vld = 1'b1; mm_rdy = 1'b1; mm_done = 1'b1;
      cyc = 0;
      while (done_seen < d0 + 5 && cyc < 3000) begin tick(); cyc++; end
      param_vld = 1'b0; gen_vld = 1'b0; src_vld = 1'b0; mm_rdy = 1'b0; mm_done = 1'b0;
      check_val("b2b_done_count", done_seen - d0, 5);
      check_val("b2b_gen_pulses", gen_pulses - g0, 5);
      for (int i = 1; i < gs_times.size(); i++)
         check_val("b2b_slot_period", gs_times[i] - gs_times[i-1], MR + 4);
      tick();
      check_val("b2b_final_cnt", slot_cnt, 1);
      check_val("b2b_idle", busy, 0);
      check_val("b2b_sb_empty", exp_q.size(), 0);
      check_val("b2b_cnt_q_empty", cnt_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/slot_sched.md
Name: slot_sched

Overview:
- Per-slot sequencer for the sparse-matrix datapath.
- Accepts one chaos-parameter set per slot and triggers CORDIC/CSC matrix generation.
- Waits for the generated sparse matrix, then gates exactly MAT_RANK source samples into the matrix multiplier.
- Waits for multiplier completion before accepting the next parameter set, so parameters never change mid-slot.

Parameters:
- SUBCAR_NUM, 16, subcarriers per OFDM symbol.
- OFDM_SYM_NUM, 16, OFDM symbols per slot; MAT_RANK = SUBCAR_NUM*OFDM_SYM_NUM (local).
- PARAM_W, 160, width of packed parameter bundle {x1,x2,x3,z1,z2}, 5x32.
- CNT_W, 16, slot counter width.
- GEN_TIMEOUT, 1024, max cycles in GEN before error abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- abort  in  1  synchronous abort to IDLE
- param_in  in  PARAM_W  packed random parameters
- param_vld  in  1  parameter valid
- param_rdy  out  1  parameter ready; 1 only in IDLE
- param_q  out  PARAM_W  latched parameters held for the whole slot
- gen_start  out  1  one-cycle pulse launching CORDIC/CSC generation
- gen_vld  in  1  sparse matrix valid (CSC output valid)
- gen_rdy  out  1  sparse matrix ready; 1 only in GEN
- src_vld  in  1  upstream sample valid
- src_rdy  out  1  upstream sample ready
- mm_vld  out  1  multiplier sample valid
- mm_rdy  in  1  multiplier sample ready
- mm_last  out  1  marks final sample of the slot
- sample_idx  out  clog2(MAT_RANK)  index of the current sample
- mm_done  in  1  multiplier finished the slot (pulse)
- slot_done  out  1  one-cycle pulse at slot end
- slot_cnt  out  CNT_W  completed-slot count
- busy  out  1  state != IDLE
- err  out  1  sticky GEN timeout flag

Behaviour:
- Reset values:
  - state=IDLE; param_q=0; gen_start=0; sample_idx=0; slot_done=0; slot_cnt=0; err=0.
  - All combinational outputs derive from the state register: param_rdy=1, busy=0, gen_rdy=0, mm_vld=0, src_rdy=0.
- IDLE:
  - param_rdy=1.
  - On param_vld&param_rdy: latch param_in into param_q, gen_start=1 for exactly the next cycle, clear timeout counter, go to GEN.
- GEN:
  - gen_rdy=1.
  - On gen_vld&gen_rdy: go to STREAM with sample_idx=0.
  - Timeout counter increments each GEN cycle. When it reaches GEN_TIMEOUT-1 with no handshake: set err, go to IDLE.
  - A handshake on that same final cycle wins: go to STREAM, err unchanged.
- STREAM:
  - Combinational pass-through, zero latency: mm_vld=src_vld, src_rdy=mm_rdy.
  - mm_last = (sample_idx==MAT_RANK-1).
  - Each src_vld&mm_rdy increments sample_idx.
  - On the handshake with mm_last=1: sample_idx returns to 0, go to DRAIN.
  - Outside STREAM, mm_vld=0 and src_rdy=0 regardless of inputs.
- DRAIN:
  - Wait for mm_done. When it arrives: slot_done=1 next cycle, slot_cnt+1 (wraps 2^CNT_W-1 -> 0), go to IDLE.
  - mm_done is ignored in every other state.
- param_q updates only on the IDLE handshake and is stable through GEN/STREAM/DRAIN.
- abort:
  - Highest priority. From any state it goes to IDLE next cycle.
  - Clears sample_idx and the timeout counter; no slot_done; slot_cnt and param_q unchanged.
  - An abort coinciding with a handshake discards that handshake's state effect (e.g. an abort in IDLE does not latch param_in or pulse gen_start).
- err clears only on rst_n.
- Reset mid-slot: outputs take reset values immediately (async assert); release is synchronised externally.
- Back-to-back slots: param_rdy rises the cycle after slot_done. Minimum slot period = MAT_RANK+4 cycles, with ideal upstream/downstream.

Test Plan:
- Nominal slot (MAT_RANK=256):
  - Stimulus: param_in=0x...A5, gen_vld 5 cycles after gen_start, src/mm always ready, mm_done 3 cycles after last.
  - Required: exactly 256 mm handshakes, mm_last only on idx 255, slot_done once, slot_cnt=1, param_q=0x...A5 throughout.
- Backpressure:
  - Stimulus: mm_rdy toggles 1/0, src_vld random 50%.
  - Required: sample_idx advances only on src_vld&mm_rdy, no sample lost or duplicated, total 256, src_rdy==mm_rdy in STREAM.
- Gating outside STREAM:
  - Stimulus: src_vld=1 and mm_done pulses during IDLE/GEN.
  - Required: mm_vld=0, src_rdy=0, no state change from mm_done.
- GEN timeout (GEN_TIMEOUT=8):
  - Stimulus: never assert gen_vld.
  - Required: err=1 after 8 GEN cycles, return to IDLE, param_rdy=1, slot_cnt unchanged.
  - Follow-up slot still completes with err staying 1.
- Abort mid-STREAM:
  - Stimulus: abort at sample_idx=100.
  - Required: next cycle IDLE, sample_idx=0, no slot_done, slot_cnt unchanged; next slot streams a full 256 samples.
- Counter wrap and back-to-back (CNT_W=2):
  - Stimulus: 5 consecutive slots with param_vld held high.
  - Required: slot_cnt sequence 1,2,3,0,1; param_rdy asserted one cycle after each slot_done; gen_start exactly one pulse per slot.
